flag_register_unit: RTL and testbench

- Producer side of the execute-stage condition path. Captures the NZCV flags generated by the ALU for flag-setting instructions and holds the architectural flag state.
- Presents that state to the condition checker, both registered and as a same-cycle forwarded value.
- Provides a one-deep shadow save/restore for trap entry/exit, plus a saturating update counter for performance monitoring.

---
 rtl/flag_register_unit.sv | 104 ++++++++++
 tb/tb_flag_register_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/flag_register_unit.sv
// NZCV flag register for the execute-stage condition path: instruction flag writes,
// same-cycle forwarding, one-deep shadow save/restore and a saturating update counter.
module flag_register_unit #(
  parameter int unsigned CNT_W       = 16,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidE,
  input  logic             CondEx,
  input  logic [1:0]       FlagW,
  input  logic [3:0]       ALUFlags,
  input  logic             stall,
  input  logic             flush,
  input  logic             save,
  input  logic             restore,
  output logic [3:0]       Flags,
  output logic [3:0]       FlagsFwd,
  output logic             FlagsUpdated,
  output logic             SavedState,
  output logic             SaveOverrun,
  output logic             RestoreErr,
  output logic [CNT_W-1:0] UpdCount
);

  typedef enum logic [0:0] {StNormal, StSaved} state_e;

  state_e           state_q;
  logic [3:0]       flags_q, shadow_q, flags_d;
  logic             upd_q, overrun_q, rerr_q;
  logic [CNT_W-1:0] cnt_q;

  logic active, we, do_restore, do_save, wr_nz, wr_cv, write_any;

  always_comb begin
    active     = ~rst & ~stall;
    we         = ValidE & CondEx & ~flush & active;
    // Only a restore from SAVED changes anything; it beats both save and the write.
    do_restore = active & restore & (state_q == StSaved);
    do_save    = active & save & ~do_restore;
    wr_nz      = we & FlagW[1] & ~do_restore;
    wr_cv      = we & FlagW[0] & ~do_restore;
    write_any  = wr_nz | wr_cv;
    flags_d    = flags_q;
    if (do_restore) begin
      flags_d = shadow_q;
    end else begin
      if (wr_nz) flags_d[1:0] = ALUFlags[1:0];
      if (wr_cv) flags_d[3:2] = ALUFlags[3:2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StNormal;
      flags_q   <= RESET_FLAGS;
      shadow_q  <= 4'b0000;
      upd_q     <= 1'b0;
      overrun_q <= 1'b0;
      rerr_q    <= 1'b0;
      cnt_q     <= '0;
    end else if (stall) begin
      upd_q     <= 1'b0;
      overrun_q <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      upd_q     <= write_any;
      overrun_q <= 1'b0;
      rerr_q    <= 1'b0;
      if (write_any && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      case (state_q)
        StNormal: begin
          if (do_save) begin
            shadow_q <= flags_q;
            state_q  <= StSaved;
          end else if (restore) begin
            rerr_q <= 1'b1;
          end
        end
        StSaved: begin
          if (do_restore) begin
            state_q <= StNormal;
          end else if (do_save) begin
            shadow_q  <= flags_q;
            overrun_q <= 1'b1;
          end
        end
        default: state_q <= StNormal;
      endcase
    end
  end

  assign Flags        = flags_q;
  assign FlagsFwd     = flags_d;
  assign FlagsUpdated = upd_q;
  assign SavedState   = (state_q == StSaved);
  assign SaveOverrun  = overrun_q;
  assign RestoreErr   = rerr_q;
  assign UpdCount     = cnt_q;

endmodule

// File: tb/tb_flag_register_unit.sv
// Directed bench for flag_register_unit: behavioural model checked every cycle plus
// hand-computed literal expectations along the directed sequence.
module tb_flag_register_unit;

  localparam int unsigned CW = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst, ValidE, CondEx, stall, flush, save, restore;
  logic [1:0] FlagW;
  logic [3:0] ALUFlags;
  logic [3:0] Flags, FlagsFwd;
  logic FlagsUpdated, SavedState, SaveOverrun, RestoreErr;
  logic [CW-1:0] UpdCount;

  int total = 0;
  int bad = 0;

  flag_register_unit #(.CNT_W(CW), .RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .rst(rst), .ValidE(ValidE), .CondEx(CondEx), .FlagW(FlagW),
    .ALUFlags(ALUFlags), .stall(stall), .flush(flush), .save(save), .restore(restore),
    .Flags(Flags), .FlagsFwd(FlagsFwd), .FlagsUpdated(FlagsUpdated),
    .SavedState(SavedState), .SaveOverrun(SaveOverrun), .RestoreErr(RestoreErr),
    .UpdCount(UpdCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: architectural state described directly by the rules.
  logic [3:0] m_flags, m_shadow;
  bit m_saved, m_upd, m_ovr, m_err, m_ok;
  int m_cnt;

  function automatic logic [3:0] merge(input logic [3:0] old, input logic [1:0] fw,
                                       input logic [3:0] alu);
    logic [3:0] r;
    r = old;
    if (fw[1]) begin r[0] = alu[0]; r[1] = alu[1]; end
    if (fw[0]) begin r[2] = alu[2]; r[3] = alu[3]; end
    return r;
  endfunction

  function automatic bit instr_writes();
    return ValidE && CondEx && !flush && (FlagW != 2'b00);
  endfunction

  function automatic logic [3:0] m_fwd();
    if (rst || stall) return m_flags;
    if (restore && m_saved) return m_shadow;
    if (instr_writes()) return merge(m_flags, FlagW, ALUFlags);
    return m_flags;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ok <= 1'b1;
      m_flags <= 4'b0000; m_shadow <= 4'b0000; m_saved <= 1'b0;
      m_upd <= 1'b0; m_ovr <= 1'b0; m_err <= 1'b0; m_cnt <= 0;
    end else if (stall) begin
      m_upd <= 1'b0; m_ovr <= 1'b0; m_err <= 1'b0;
    end else begin
      m_upd <= 1'b0; m_ovr <= 1'b0; m_err <= 1'b0;
      if (restore && m_saved) begin
        m_flags <= m_shadow;
        m_saved <= 1'b0;
      end else begin
        if (save) begin
          m_ovr <= m_saved;
          m_shadow <= m_flags;
          m_saved <= 1'b1;
        end else if (restore) begin
          m_err <= 1'b1;
        end
        if (instr_writes()) begin
          m_flags <= merge(m_flags, FlagW, ALUFlags);
          m_upd <= 1'b1;
          m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("Flags", 32'(Flags), 32'(m_flags));
      chk("FlagsFwd", 32'(FlagsFwd), 32'(m_fwd()));
      chk("FlagsUpdated", 32'(FlagsUpdated), 32'(m_upd));
      chk("SavedState", 32'(SavedState), 32'(m_saved));
      chk("SaveOverrun", 32'(SaveOverrun), 32'(m_ovr));
      chk("RestoreErr", 32'(RestoreErr), 32'(m_err));
      chk("UpdCount", 32'(UpdCount), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit c, input logic [1:0] fw, input logic [3:0] alu,
                       input bit st, input bit fl, input bit sv, input bit rs);
    ValidE = v; CondEx = c; FlagW = fw; ALUFlags = alu;
    stall = st; flush = fl; save = sv; restore = rs;
  endtask

  task automatic idle();
    drive(0, 0, 2'b00, 4'b0000, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    m_ok = 1'b0;
    do_reset();
    chk("reset Flags", 32'(Flags), 32'h0);
    chk("reset UpdCount", 32'(UpdCount), 32'h0);
    chk("reset SavedState", 32'(SavedState), 32'h0);

    // 1: full write
    drive(1, 1, 2'b11, 4'b1010, 0, 0, 0, 0);
    #1 chk("t1 FlagsFwd", 32'(FlagsFwd), 32'hA);
    tick();
    chk("t1 Flags", 32'(Flags), 32'hA);
    chk("t1 FlagsUpdated", 32'(FlagsUpdated), 32'h1);
    chk("t1 UpdCount", 32'(UpdCount), 32'h1);
    idle(); tick();
    chk("t1 pulse clears", 32'(FlagsUpdated), 32'h0);

    // 2: group writes
    do_reset();
    drive(1, 1, 2'b10, 4'b1111, 0, 0, 0, 0); tick();
    chk("t2 NZ only", 32'(Flags), 32'h3);
    drive(1, 1, 2'b01, 4'b0100, 0, 0, 0, 0); tick();
    chk("t2 CV only", 32'(Flags), 32'h7);

    // 3: suppressed writes
    drive(1, 0, 2'b11, 4'b0001, 0, 0, 0, 0); tick();
    chk("t3 CondEx=0", 32'(Flags), 32'h7);
    drive(1, 1, 2'b11, 4'b0001, 0, 1, 0, 0); tick();
    chk("t3 flush", 32'(Flags), 32'h7);
    drive(1, 1, 2'b11, 4'b0001, 1, 0, 0, 0); tick();
    chk("t3 stall", 32'(Flags), 32'h7);
    drive(0, 1, 2'b11, 4'b0001, 0, 0, 0, 0); tick();
    chk("t3 ValidE=0", 32'(Flags), 32'h7);
    chk("t3 FlagsUpdated", 32'(FlagsUpdated), 32'h0);
    chk("t3 UpdCount", 32'(UpdCount), 32'h2);

    // 4: save with write, restore, restore error
    drive(1, 1, 2'b11, 4'b1000, 0, 0, 1, 0); tick();
    chk("t4 SavedState", 32'(SavedState), 32'h1);
    chk("t4 Flags", 32'(Flags), 32'h8);
    chk("t4 FlagsUpdated", 32'(FlagsUpdated), 32'h1);
    idle(); tick();
    drive(0, 0, 2'b00, 4'b0000, 1, 0, 0, 1); tick();
    chk("t4 stall blocks restore", 32'(SavedState), 32'h1);
    drive(0, 0, 2'b00, 4'b0000, 0, 0, 0, 1);
    #1 chk("t4 restore FlagsFwd", 32'(FlagsFwd), 32'h7);
    tick();
    chk("t4 restored Flags", 32'(Flags), 32'h7);
    chk("t4 SavedState clear", 32'(SavedState), 32'h0);
    tick();
    chk("t4 RestoreErr", 32'(RestoreErr), 32'h1);
    chk("t4 Flags held", 32'(Flags), 32'h7);
    idle(); tick();
    chk("t4 RestoreErr clears", 32'(RestoreErr), 32'h0);

    // 5: overrun, then save+restore with a discarded write
    drive(0, 0, 2'b00, 4'b0000, 0, 0, 1, 0); tick();
    tick();
    chk("t5 back-to-back overrun", 32'(SaveOverrun), 32'h1);
    drive(1, 1, 2'b11, 4'b1100, 0, 0, 0, 0); tick();
    drive(0, 0, 2'b00, 4'b0000, 0, 0, 1, 0); tick();
    chk("t5 SaveOverrun", 32'(SaveOverrun), 32'h1);
    drive(1, 1, 2'b11, 4'b0000, 0, 0, 0, 0); tick();
    chk("t5 Flags before restore", 32'(Flags), 32'h0);
    drive(1, 1, 2'b11, 4'b0101, 0, 0, 1, 1); tick();
    chk("t5 restore newer shadow", 32'(Flags), 32'hC);
    chk("t5 save ignored", 32'(SavedState), 32'h0);
    chk("t5 no overrun", 32'(SaveOverrun), 32'h0);
    chk("t5 write discarded", 32'(FlagsUpdated), 32'h0);
    chk("t5 UpdCount", 32'(UpdCount), 32'h5);

    // 6: saturation, then reset from SAVED
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 2'b11, 4'(i), 0, 0, 0, 0); tick();
    end
    chk("t6 saturated", 32'(UpdCount), 32'hF);
    tick();
    chk("t6 stays saturated", 32'(UpdCount), 32'hF);
    drive(0, 0, 2'b00, 4'b0000, 0, 0, 1, 0); tick();
    chk("t6 in SAVED", 32'(SavedState), 32'h1);
    drive(1, 1, 2'b11, 4'b1111, 1, 0, 1, 1);
    rst = 1'b1; tick();
    rst = 1'b0; idle();
    chk("t6 rst Flags", 32'(Flags), 32'h0);
    chk("t6 rst FlagsFwd", 32'(FlagsFwd), 32'h0);
    chk("t6 rst SavedState", 32'(SavedState), 32'h0);
    chk("t6 rst UpdCount", 32'(UpdCount), 32'h0);
    chk("t6 rst pulses", 32'({FlagsUpdated, SaveOverrun, RestoreErr}), 32'h0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
